// File: rtl/pc_unit.sv
// pc_unit: program counter with sequential/branch/jump/call/return and a circular return-address stack.
// Latency: pc updates one falling edge after inputs are sampled; pc_next is combinational.
// Backpressure: stall holds pc and the RAS for that edge and clears ras_err; op is ignored while stalled.
module pc_unit #(
  parameter int unsigned                ADDR_W     = 8,
  parameter int unsigned                OFFSET_W   = 8,
  parameter int unsigned                STEP       = 1,
  parameter int unsigned                RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0]          RESET_ADDR = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              stall,
  input  logic [2:0]                        op,
  input  logic [OFFSET_W-1:0]               offset,
  input  logic [ADDR_W-1:0]                 target,
  output logic [ADDR_W-1:0]                 pc,
  output logic [ADDR_W-1:0]                 pc_next,
  output logic [$clog2(RAS_DEPTH+1)-1:0]    ras_count,
  output logic                              ras_full,
  output logic                              ras_empty,
  output logic                              ras_err
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH+1);

  localparam logic [2:0] OP_SEQ    = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  // Stack storage; contents are don't-care after reset, so no reset here.
  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];

  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] off_sext;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] ras_top;
  logic [PTR_W-1:0]  top_inc;
  logic [PTR_W-1:0]  top_dec;
  logic              full;
  logic              empty;
  logic              do_push;
  logic              ret_req;
  logic              do_pop;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);

  // Both adders wrap modulo 2^ADDR_W; a negative offset is added in two's complement.
  assign seq_addr    = pc_q + ADDR_W'(STEP);
  assign off_sext    = ADDR_W'($signed(offset));
  assign branch_addr = seq_addr + off_sext;
  assign ras_top     = ras_mem_q[top_q];

  // Circular pointer arithmetic that also works for non-power-of-two depths.
  assign top_inc = (top_q == PTR_LAST) ? '0 : top_q + PTR_W'(1);
  assign top_dec = (top_q == '0) ? PTR_LAST : top_q - PTR_W'(1);

  // A push always happens on CALL (overflow overwrites the oldest slot);
  // a pop only happens when something is actually on the stack.
  assign do_push = !stall && (op == OP_CALL);
  assign ret_req = !stall && (op == OP_RET);
  assign do_pop  = ret_req && !empty;

  // Next-PC select; underflowing RET and reserved opcodes fall through to seq.
  always_comb begin
    pc_d = seq_addr;
    if (stall) begin
      pc_d = pc_q;
    end else begin
      case (op)
        OP_SEQ:    pc_d = seq_addr;
        OP_BRANCH: pc_d = branch_addr;
        OP_JUMP:   pc_d = target;
        OP_CALL:   pc_d = target;
        OP_RET:    pc_d = empty ? seq_addr : ras_top;
        default:   pc_d = seq_addr;
      endcase
    end
  end

  // Stack pointer, occupancy and error pulse next-state.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (do_push) begin
      top_d = top_inc;
      if (!full) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      err_d = full;
    end else if (ret_req) begin
      if (do_pop) begin
        top_d = top_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end
      err_d = empty;
    end
  end

  // Architectural state advances on the falling edge; reset acts immediately.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_ADDR;
      top_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Push writes the return address into the slot the pointer advances to.
  always_ff @(negedge clk) begin
    if (reset && do_push) begin
      ras_mem_q[top_inc] <= seq_addr;
    end
  end

  assign pc        = pc_q;
  assign pc_next   = pc_d;
  assign ras_count = cnt_q;
  assign ras_full  = full;
  assign ras_empty = empty;
  assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic       clk;
  logic       reset;
  logic       stall;
  logic [2:0] op;
  logic [7:0] offset;
  logic [7:0] target;
  logic [7:0] pc;
  logic [7:0] pc_next;
  logic [2:0] ras_count;
  logic       ras_full;
  logic       ras_empty;
  logic       ras_err;

  int checks = 0;
  int errors = 0;

  pc_unit #(
    .ADDR_W(8), .OFFSET_W(8), .STEP(1), .RAS_DEPTH(4), .RESET_ADDR(8'd0)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .op(op), .offset(offset),
    .target(target), .pc(pc), .pc_next(pc_next), .ras_count(ras_count),
    .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic [2:0] op;
    logic [7:0] offset;
    logic [7:0] target;
    logic [7:0] exp_pc;
    logic [2:0] exp_cnt;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input int e_pc, input int e_cnt, input int e_err);
    chk({name, " pc"}, pc, e_pc);
    chk({name, " count"}, ras_count, e_cnt);
    chk({name, " err"}, ras_err, e_err);
    chk({name, " full"}, ras_full, (e_cnt == 4) ? 1 : 0);
    chk({name, " empty"}, ras_empty, (e_cnt == 0) ? 1 : 0);
  endtask

  // Drive after an edge, step to the next falling edge, sample 2 time units later.
  task automatic drive(input logic s, input logic [2:0] o, input logic [7:0] off, input logic [7:0] tgt);
    stall  = s;
    op     = o;
    offset = off;
    target = tgt;
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  function automatic vec_t mk(input logic s, input logic [2:0] o, input logic [7:0] off,
                              input logic [7:0] tgt, input logic [7:0] epc,
                              input logic [2:0] ecnt, input logic eerr);
    vec_t v;
    v.stall = s; v.op = o; v.offset = off; v.target = tgt;
    v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_err = eerr;
    return v;
  endfunction

  initial begin
    // Table continues from pc=2 with an empty stack (end of the wrap run).
    vecs.push_back(mk(0, 3'd2, 8'h00, 8'd10,  8'd10,  3'd0, 0)); // jump to 10
    vecs.push_back(mk(0, 3'd1, 8'hFB, 8'd0,   8'd6,   3'd0, 0)); // 11-5
    vecs.push_back(mk(0, 3'd1, 8'h7F, 8'd0,   8'd134, 3'd0, 0)); // 7+127
    vecs.push_back(mk(1, 3'd2, 8'h00, 8'd55,  8'd134, 3'd0, 0)); // stall
    vecs.push_back(mk(1, 3'd2, 8'h00, 8'd55,  8'd134, 3'd0, 0));
    vecs.push_back(mk(1, 3'd2, 8'h00, 8'd55,  8'd134, 3'd0, 0));
    vecs.push_back(mk(0, 3'd2, 8'h00, 8'd20,  8'd20,  3'd0, 0));
    vecs.push_back(mk(0, 3'd3, 8'h00, 8'd100, 8'd100, 3'd1, 0)); // call, push 21
    vecs.push_back(mk(0, 3'd3, 8'h00, 8'd200, 8'd200, 3'd2, 0)); // call, push 101
    vecs.push_back(mk(0, 3'd4, 8'h00, 8'd0,   8'd101, 3'd1, 0));
    vecs.push_back(mk(0, 3'd4, 8'h00, 8'd0,   8'd21,  3'd0, 0));
    vecs.push_back(mk(0, 3'd2, 8'h00, 8'd0,   8'd0,   3'd0, 0)); // overflow run
    vecs.push_back(mk(0, 3'd3, 8'h00, 8'd10,  8'd10,  3'd1, 0)); // push 1
    vecs.push_back(mk(0, 3'd3, 8'h00, 8'd20,  8'd20,  3'd2, 0)); // push 11
    vecs.push_back(mk(0, 3'd3, 8'h00, 8'd30,  8'd30,  3'd3, 0)); // push 21
    vecs.push_back(mk(0, 3'd3, 8'h00, 8'd40,  8'd40,  3'd4, 0)); // push 31
    vecs.push_back(mk(0, 3'd3, 8'h00, 8'd50,  8'd50,  3'd4, 1)); // push 41 over 1
    vecs.push_back(mk(0, 3'd4, 8'h00, 8'd0,   8'd41,  3'd3, 0));
    vecs.push_back(mk(0, 3'd4, 8'h00, 8'd0,   8'd31,  3'd2, 0));
    vecs.push_back(mk(0, 3'd4, 8'h00, 8'd0,   8'd21,  3'd1, 0));
    vecs.push_back(mk(0, 3'd4, 8'h00, 8'd0,   8'd11,  3'd0, 0));
    vecs.push_back(mk(0, 3'd2, 8'h00, 8'd50,  8'd50,  3'd0, 0)); // underflow
    vecs.push_back(mk(0, 3'd4, 8'h00, 8'd0,   8'd51,  3'd0, 1));
    vecs.push_back(mk(0, 3'd0, 8'h00, 8'd0,   8'd52,  3'd0, 0));
    vecs.push_back(mk(0, 3'd4, 8'h00, 8'd0,   8'd53,  3'd0, 1)); // back-to-back errors
    vecs.push_back(mk(0, 3'd4, 8'h00, 8'd0,   8'd54,  3'd0, 1));
    vecs.push_back(mk(1, 3'd4, 8'h00, 8'd0,   8'd54,  3'd0, 0)); // stall clears err
    vecs.push_back(mk(0, 3'd7, 8'h12, 8'd99,  8'd55,  3'd0, 0)); // reserved op = seq
    vecs.push_back(mk(0, 3'd2, 8'h00, 8'd2,   8'd2,   3'd0, 0));
    vecs.push_back(mk(0, 3'd1, 8'h80, 8'd0,   8'd131, 3'd0, 0)); // 3-128 wraps
    vecs.push_back(mk(0, 3'd3, 8'h00, 8'd77,  8'd77,  3'd1, 0)); // call then ret
    vecs.push_back(mk(0, 3'd4, 8'h00, 8'd0,   8'd132, 3'd0, 0));

    reset = 1'b0;
    drive(0, 3'd0, 8'h00, 8'h00);
    #23;
    chk_state("reset", 0, 0, 0);
    chk("reset pc_next", pc_next, 1);

    // Release after a rising edge; nothing may move until the next falling edge.
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("release hold pc", pc, 0);

    // Sequential wrap: 258 edges.
    for (int i = 1; i <= 258; i++) begin
      step();
      chk("wrap pc", pc, i % 256);
      chk("wrap pc_next", pc_next, (i + 1) % 256);
    end

    foreach (vecs[k]) begin
      drive(vecs[k].stall, vecs[k].op, vecs[k].offset, vecs[k].target);
      #1;
      chk($sformatf("vec%0d pc_next", k), pc_next, vecs[k].exp_pc);
      step();
      chk_state($sformatf("vec%0d", k), vecs[k].exp_pc, vecs[k].exp_cnt, vecs[k].exp_err);
    end

    // Asynchronous reset in the middle of a call sequence.
    drive(0, 3'd2, 8'h00, 8'd5);   step();
    drive(0, 3'd3, 8'h00, 8'd150); step();
    drive(0, 3'd3, 8'h00, 8'd200); step();
    chk_state("pre-reset", 200, 2, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk_state("async reset", 0, 0, 0);
    drive(0, 3'd4, 8'h00, 8'd0);
    step();
    chk_state("reset held", 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk_state("post release", 0, 0, 0);
    step();
    chk_state("ret after reset", 1, 0, 1);
    drive(0, 3'd0, 8'h00, 8'd0);
    step();
    chk_state("err one cycle", 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the lab processor, generalising the single-step counter: sequential increment, stall, PC-relative branch, absolute jump, and call/return through an internal return-address stack (RAS). It sits at the head of the fetch path. It drives the instruction-memory read address from the registered `pc` and exposes a combinational `pc_next` for prefetch. All state updates on the falling edge of `clk`, matching the existing datapath blocks.

## Interface
- `ADDR_W`, default 8: PC and target width.
- `OFFSET_W`, default 8: branch offset width. Signed two's complement, `OFFSET_W <= ADDR_W`.
- `STEP`, default 1: increment per instruction.
- `RAS_DEPTH`, default 4: return-stack entries, ≥ 2.
- `RESET_ADDR`, default 0: PC value held in reset.

- `clk`, input, 1: clock. State updates on the falling edge.
- `reset`, input, 1: asynchronous, active-low reset. 0 = in reset.
- `stall`, input, 1: hold PC and RAS this edge. Overrides `op`.
- `op`, input, 3: 000 SEQ, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET. 101–111 are reserved and treated as SEQ.
- `offset`, input, OFFSET_W: signed branch displacement, in addresses.
- `target`, input, ADDR_W: absolute destination for JUMP and CALL.
- `pc`, output, ADDR_W: registered current PC.
- `pc_next`, output, ADDR_W: combinational value `pc` takes at the next falling edge.
- `ras_count`, output, $clog2(RAS_DEPTH+1): occupied entries.
- `ras_full`, output, 1: `ras_count == RAS_DEPTH`.
- `ras_empty`, output, 1: `ras_count == 0`.
- `ras_err`, output, 1: registered one-cycle pulse on RAS overflow or underflow.

## Operation
- `seq = pc + STEP`, computed modulo 2^ADDR_W.
- Per-op `pc_next` and RAS effect:
  - SEQ: `seq`.
  - BRANCH: `seq + sext(offset)`. The offset is sign-extended to ADDR_W and the add is two's complement modulo 2^ADDR_W. A negative offset is added directly, never via a separate subtractor.
  - JUMP: `target`.
  - CALL: `target`. Push `seq` onto the RAS.
  - RET: top of RAS, then pop.
- `stall`=1: `pc_next = pc`. RAS, `ras_count` and `ras_err` do not change, except that `ras_err` returns to 0.
- RAS is a circular buffer with a top pointer and a count.
- CALL when full (overflow):
  - push still happens and overwrites the oldest entry;
  - `ras_count` stays RAS_DEPTH;
  - PC goes to `target`;
  - `ras_err` pulses.
- RET when empty (underflow):
  - behaves as SEQ;
  - `ras_count` stays 0;
  - `ras_err` pulses.
- Flags `ras_full` and `ras_empty` are decoded from `ras_count`, never stored separately.
- Reset asserted (`reset`=0), at any time, including mid-stall or mid-call sequence:
  - `pc` = RESET_ADDR;
  - `ras_count` = 0, so `ras_empty`=1 and `ras_full`=0;
  - `ras_err` = 0;
  - RAS contents are don't-care.
- Reset release: the first update occurs at the first falling edge with `reset`=1.

## Timing
- Inputs are sampled at the falling edge. `pc` reflects the result after that edge: latency 1 edge.
- `pc_next` is valid combinationally whenever inputs are stable. `pc_next` after reset = RESET_ADDR + STEP, assuming SEQ and no stall.
- Back-to-back CALL/RET on consecutive edges must work with no bubble. A RET on the edge after a CALL returns the address pushed on that CALL.
- `ras_err` is high for exactly one cycle, for the edge after the offending op. Consecutive errors keep it high.
- Reset assertion affects outputs immediately, without waiting for a clock edge.
- Reset deassertion is synchronous in effect: nothing changes until the next falling edge.

## Test plan
All scenarios use the defaults: ADDR_W=8, OFFSET_W=8, STEP=1, RAS_DEPTH=4, RESET_ADDR=0.

- **Reset and sequential wrap:** reset low, then release with op=SEQ for 258 edges → `pc` runs 0,1,…,255,0,1; `pc_next` is always `pc`+1 mod 256.
- **Branch and stall:** at `pc`=10, BRANCH with offset=8'hFB (−5) → `pc`=6. Then offset=8'h7F → `pc`=134. Then stall=1 for 3 edges with op=JUMP → `pc` stays 134 and `ras_count` is unchanged.
- **Call/return nesting:** at `pc`=20, CALL target=100 → `pc`=100 and `ras_count`=1. At 100, CALL target=200 → `ras_count`=2. RET → `pc`=101. RET → `pc`=21 and `ras_empty`=1.
- **Overflow:** 5 CALLs from `pc`=0,10,20,30,40, each targeting the next → `ras_full`=1 and `ras_err` pulses on the 5th. Then 4 RETs return 41,31,21,11 (the entry for 1 is lost), and `ras_empty`=1.
- **Underflow:** with RAS empty, RET at `pc`=50 → `pc`=51, `ras_err`=1 for one cycle, `ras_count`=0.
- **Async reset mid-operation:** after 2 CALLs (`pc`=200), drop `reset` between edges → `pc`=0 and `ras_count`=0 immediately. After release, RET → `pc`=1 and `ras_err` pulses.
